ifetch_pc: RTL and testbench
============================

IFETCH_PC -- requirements
Module: ifetch_pc

Interface
REQ-001 Parameters: RESET_PC, default 32'h0000_0000, PC loaded on reset; CNT_W, default 16, width of the mispredict counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 StallF  in  1  hold PC register.
REQ-005 StallD  in  1  hold IF/ID register.
REQ-006 InstrF  in  32  instruction word from instruction memory at PCF.
REQ-007 JumpPre, JumpPrePC  in  1/32  predictor says taken, with predicted target (ID stage).
REQ-008 JumpD, JumpTargetD  in  1/32  unconditional j/jal decoded in ID, with target.
REQ-009 BranchMEM, PredTakenMEM, PCSrcMEM  in  1 each  branch in MEM, its carried prediction, actual outcome.
REQ-010 PCBranchMEM, PCPlus4MEM  in  32 each  resolved target and fall-through.
REQ-011 PCF  out  32  current fetch address.
REQ-012 InstrD, PCPlus4D  out  32 each  IF/ID register contents.
REQ-013 PredTakenD  out  1  prediction tag for the instruction in ID, carried downstream.
REQ-014 FlushDE  out  1  combinational request to squash ID/EX on recovery.
REQ-015 MispredCnt  out  CNT_W  saturating count of mispredictions.

Function
REQ-016 Mispredict is BranchMEM && (PredTakenMEM != PCSrcMEM), combinational.
REQ-017 Next-PC priority:
  - Mispredict: PCSrcMEM ? PCBranchMEM : PCPlus4MEM.
  - else JumpD: JumpTargetD.
  - else JumpPre: JumpPrePC.
  - else PCF+4, modulo 2^32, wrap with no flag.
REQ-018 PCF updates on every rising edge unless StallF=1; Mispredict overrides StallF.
REQ-019 IF/ID register loads {InstrF, PCF+4} when StallD=0, else holds.
REQ-020 IF/ID is flushed (InstrD=32'h0, PredTakenD=0) in the same edge as any redirect: Mispredict, JumpD or JumpPre. A flush overrides StallD.
REQ-021 PredTakenD is set to 1 only when the word loaded into ID was fetched from a JumpPrePC redirect. It tags the fetched target, which is the instruction after the branch.
REQ-022 FSM has two states:
  - RUN -> RECOVER on Mispredict.
  - RECOVER -> RUN unconditionally after one cycle.
  - In RECOVER, FlushDE=1 and JumpPre is ignored.
REQ-023 FlushDE=1 in any cycle where Mispredict=1 or the state is RECOVER, else 0.
REQ-024 MispredCnt increments by 1 on each edge where Mispredict=1, and saturates at all-ones.
REQ-025 If Mispredict and JumpD occur together, Mispredict wins, the jump is squashed, and the count increments once.
REQ-026 No combinational path from InstrF to PCF.

Reset
REQ-027 With rst_n=0, all of the following are forced asynchronously:
  - PCF=RESET_PC.
  - InstrD=0, PCPlus4D=RESET_PC+4.
  - PredTakenD=0, MispredCnt=0.
  - State is RUN.
REQ-028 After rst_n rises, the first edge fetches RESET_PC+4. A reset mid-recovery abandons the recovery.

Structure
REQ-029 The shared pipeline package holds RESET_PC, the NOP encoding 32'h0, and the FSM state enum {RUN, RECOVER}.
REQ-030 One sub-module, ifid_reg, contains the IF/ID register with stall and flush. Next-PC logic and the FSM stay in ifetch_pc.

Verification
REQ-031 Reset, then 4 free cycles -> PCF = 0, 4, 8, 12, 16; FlushDE=0.
REQ-032 JumpPre=1, JumpPrePC=32'h40 at PCF=8 -> next PCF=32'h40; InstrD=0; on the following load, PredTakenD=1.
REQ-033 BranchMEM=1, PredTakenMEM=1, PCSrcMEM=0, PCPlus4MEM=32'h14, with StallF=1 -> PCF=32'h14; FlushDE=1 for 2 cycles; MispredCnt=1.
REQ-034 Mispredict (PCSrcMEM=1, PCBranchMEM=32'h80) together with JumpD (JumpTargetD=32'h200) -> PCF=32'h80.
REQ-035 Force MispredCnt to all-ones, then Mispredict -> MispredCnt stays all-ones.
REQ-036 PCF=32'hFFFF_FFFC, no redirect -> PCF=0. Then rst_n pulsed low mid-RECOVER -> PCF=RESET_PC, state RUN, FlushDE=0.

Source files
------------

// File: rtl/ifetch_pc_pkg.sv
// Shared fetch-pipeline definitions: reset PC, NOP encoding, fetch FSM states
// and the IF/ID payload layout.
package ifetch_pc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        RUN,
        RECOVER
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            pred_taken;
    } ifid_t;

endpackage

// File: rtl/ifetch_pc_if.sv
// Fetch-stage bus: stall/redirect inputs from later stages and the IF/ID outputs.
interface ifetch_pc_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic        StallF;
    logic        StallD;
    logic [31:0] InstrF;
    logic        JumpPre;
    logic [31:0] JumpPrePC;
    logic        JumpD;
    logic [31:0] JumpTargetD;
    logic        BranchMEM;
    logic        PredTakenMEM;
    logic        PCSrcMEM;
    logic [31:0] PCBranchMEM;
    logic [31:0] PCPlus4MEM;

    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCPlus4D;
    logic             PredTakenD;
    logic             FlushDE;
    logic [CNT_W-1:0] MispredCnt;

    modport master (
        output StallF, StallD, InstrF, JumpPre, JumpPrePC, JumpD, JumpTargetD,
               BranchMEM, PredTakenMEM, PCSrcMEM, PCBranchMEM, PCPlus4MEM,
        input  PCF, InstrD, PCPlus4D, PredTakenD, FlushDE, MispredCnt
    );

    modport slave (
        input  StallF, StallD, InstrF, JumpPre, JumpPrePC, JumpD, JumpTargetD,
               BranchMEM, PredTakenMEM, PCSrcMEM, PCBranchMEM, PCPlus4MEM,
        output PCF, InstrD, PCPlus4D, PredTakenD, FlushDE, MispredCnt
    );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; a flush squashes the word to NOP and wins over stall.
module ifid_reg
    import ifetch_pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = ifetch_pc_pkg::RESET_PC
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{instr: NOP, pc_plus4: RESET_PC + XLEN'(4), pred_taken: 1'b0};
        end else if (flush) begin
            q.instr      <= NOP;
            q.pred_taken <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch_pc.sv
// Fetch PC generation with branch-mispredict recovery FSM, IF/ID register
// and a saturating mispredict counter.
module ifetch_pc
    import ifetch_pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = ifetch_pc_pkg::RESET_PC,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ifetch_pc_if.slave  bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            pred_q, pred_d;
    logic            mispredict, pc_en, ifid_flush, flush_de;
    logic [CNT_W-1:0] cnt_q;
    ifid_t           ifid_d, ifid_q;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign mispredict = bus.BranchMEM && (bus.PredTakenMEM != bus.PCSrcMEM);
    assign pc_en      = mispredict || !bus.StallF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Redirect priority: mispredict, then decoded jump, then predictor (RUN only).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_plus4;
        pred_d     = 1'b0;
        flush_de   = mispredict;
        ifid_flush = 1'b0;

        case (state_q)
            RUN:     if (mispredict) state_d = RECOVER;
            RECOVER: begin
                state_d  = RUN;
                flush_de = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (mispredict) begin
            pc_d       = bus.PCSrcMEM ? bus.PCBranchMEM : bus.PCPlus4MEM;
            ifid_flush = 1'b1;
        end else if (bus.JumpD) begin
            pc_d       = bus.JumpTargetD;
            ifid_flush = 1'b1;
        end else if (bus.JumpPre && (state_q == RUN)) begin
            pc_d       = bus.JumpPrePC;
            pred_d     = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    // pred_q tags the PC as a predicted-taken target until PCF moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pred_q <= 1'b0;
        end else if (pc_en) begin
            pc_q   <= pc_d;
            pred_q <= pred_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt_q <= '0;
        else if (mispredict && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign ifid_d = '{instr: bus.InstrF, pc_plus4: pc_plus4, pred_taken: pred_q};

    ifid_reg #(
        .RESET_PC (RESET_PC)
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (bus.StallD),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.PCF        = pc_q;
    assign bus.InstrD     = ifid_q.instr;
    assign bus.PCPlus4D   = ifid_q.pc_plus4;
    assign bus.PredTakenD = ifid_q.pred_taken;
    assign bus.FlushDE    = flush_de;
    assign bus.MispredCnt = cnt_q;

endmodule

// File: tb/tb_ifetch_pc.sv
// Directed bench for ifetch_pc: sequential fetch, predictor redirect, stalls,
// mispredict recovery, jump priority, PC wrap, counter saturation, mid-recovery reset.
module tb_ifetch_pc;
    import ifetch_pc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ifetch_pc_if #(.CNT_W(16)) bus ();
    ifetch_pc_if #(.CNT_W(2))  sbus ();

    ifetch_pc #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch_pc #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.StallF = 0; bus.StallD = 0; bus.InstrF = 0;
        bus.JumpPre = 0; bus.JumpPrePC = 0; bus.JumpD = 0; bus.JumpTargetD = 0;
        bus.BranchMEM = 0; bus.PredTakenMEM = 0; bus.PCSrcMEM = 0;
        bus.PCBranchMEM = 0; bus.PCPlus4MEM = 0;
        sbus.StallF = 0; sbus.StallD = 0; sbus.InstrF = 0;
        sbus.JumpPre = 0; sbus.JumpPrePC = 0; sbus.JumpD = 0; sbus.JumpTargetD = 0;
        sbus.BranchMEM = 0; sbus.PredTakenMEM = 0; sbus.PCSrcMEM = 0;
        sbus.PCBranchMEM = 0; sbus.PCPlus4MEM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.PCF !== 32'h0) begin n_fail++; $display("FAIL rst_pcf: got %h want %h", bus.PCF, 32'h0); end
        n_cmp++; if (bus.InstrD !== NOP) begin n_fail++; $display("FAIL rst_instrd: got %h want %h", bus.InstrD, NOP); end
        n_cmp++; if (bus.PCPlus4D !== 32'h4) begin n_fail++; $display("FAIL rst_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h4); end
        n_cmp++; if (bus.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL rst_predtaken: got %b want 0", bus.PredTakenD); end
        n_cmp++; if (bus.MispredCnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", bus.MispredCnt); end
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL rst_flushde: got %b want 0", bus.FlushDE); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            bus.InstrF = 32'h1000_0000 + 32'(i);
            step();
            n_cmp++; if (bus.PCF !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pcf[%0d]: got %h want %h", i, bus.PCF, 32'(4 * i)); end
            n_cmp++; if (bus.InstrD !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL seq_instrd[%0d]: got %h want %h", i, bus.InstrD, 32'h1000_0000 + 32'(i)); end
            n_cmp++; if (bus.PCPlus4D !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pcplus4d[%0d]: got %h want %h", i, bus.PCPlus4D, 32'(4 * i)); end
            n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL seq_flushde[%0d]: got %b want 0", i, bus.FlushDE); end
        end
    endtask

    task automatic test_jump_pre();
        apply_reset();
        step();
        step();
        n_cmp++; if (bus.PCF !== 32'h8) begin n_fail++; $display("FAIL jp_start_pcf: got %h want %h", bus.PCF, 32'h8); end
        bus.JumpPre = 1; bus.JumpPrePC = 32'h40; bus.InstrF = 32'hAAAA_0008;
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL jp_flushde: got %b want 0", bus.FlushDE); end
        step();
        n_cmp++; if (bus.PCF !== 32'h40) begin n_fail++; $display("FAIL jp_pcf: got %h want %h", bus.PCF, 32'h40); end
        n_cmp++; if (bus.InstrD !== NOP) begin n_fail++; $display("FAIL jp_instrd_flush: got %h want %h", bus.InstrD, NOP); end
        n_cmp++; if (bus.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL jp_pred_flush: got %b want 0", bus.PredTakenD); end
        bus.JumpPre = 0; bus.InstrF = 32'hCAFE_0040;
        step();
        n_cmp++; if (bus.PCF !== 32'h44) begin n_fail++; $display("FAIL jp_next_pcf: got %h want %h", bus.PCF, 32'h44); end
        n_cmp++; if (bus.InstrD !== 32'hCAFE_0040) begin n_fail++; $display("FAIL jp_target_instrd: got %h want %h", bus.InstrD, 32'hCAFE_0040); end
        n_cmp++; if (bus.PredTakenD !== 1'b1) begin n_fail++; $display("FAIL jp_pred_tag: got %b want 1", bus.PredTakenD); end
        n_cmp++; if (bus.PCPlus4D !== 32'h44) begin n_fail++; $display("FAIL jp_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h44); end
        bus.InstrF = 32'hCAFE_0044;
        step();
        n_cmp++; if (bus.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL jp_pred_clear: got %b want 0", bus.PredTakenD); end
        n_cmp++; if (bus.InstrD !== 32'hCAFE_0044) begin n_fail++; $display("FAIL jp_after_instrd: got %h want %h", bus.InstrD, 32'hCAFE_0044); end
    endtask

    task automatic test_stall();
        bus.StallF = 1; bus.StallD = 1; bus.InstrF = 32'hDEAD_0000;
        step();
        n_cmp++; if (bus.PCF !== 32'h48) begin n_fail++; $display("FAIL st_both_pcf: got %h want %h", bus.PCF, 32'h48); end
        n_cmp++; if (bus.InstrD !== 32'hCAFE_0044) begin n_fail++; $display("FAIL st_both_instrd: got %h want %h", bus.InstrD, 32'hCAFE_0044); end
        bus.StallF = 0;
        step();
        n_cmp++; if (bus.PCF !== 32'h4C) begin n_fail++; $display("FAIL st_d_pcf: got %h want %h", bus.PCF, 32'h4C); end
        n_cmp++; if (bus.InstrD !== 32'hCAFE_0044) begin n_fail++; $display("FAIL st_d_instrd: got %h want %h", bus.InstrD, 32'hCAFE_0044); end
        bus.StallF = 1; bus.StallD = 0; bus.InstrF = 32'hBEEF_0000;
        step();
        n_cmp++; if (bus.PCF !== 32'h4C) begin n_fail++; $display("FAIL st_f_pcf: got %h want %h", bus.PCF, 32'h4C); end
        n_cmp++; if (bus.InstrD !== 32'hBEEF_0000) begin n_fail++; $display("FAIL st_f_instrd: got %h want %h", bus.InstrD, 32'hBEEF_0000); end
        n_cmp++; if (bus.PCPlus4D !== 32'h50) begin n_fail++; $display("FAIL st_f_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h50); end
        bus.StallF = 0;
    endtask

    task automatic test_mispredict();
        bus.BranchMEM = 1; bus.PredTakenMEM = 1; bus.PCSrcMEM = 0;
        bus.PCPlus4MEM = 32'h14; bus.PCBranchMEM = 32'h999;
        bus.StallF = 1; bus.StallD = 1; bus.JumpPre = 1; bus.JumpPrePC = 32'h700;
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b1) begin n_fail++; $display("FAIL mp_flushde_c1: got %b want 1", bus.FlushDE); end
        step();
        n_cmp++; if (bus.PCF !== 32'h14) begin n_fail++; $display("FAIL mp_pcf: got %h want %h", bus.PCF, 32'h14); end
        n_cmp++; if (bus.MispredCnt !== 16'd1) begin n_fail++; $display("FAIL mp_cnt: got %0d want 1", bus.MispredCnt); end
        n_cmp++; if (bus.InstrD !== NOP) begin n_fail++; $display("FAIL mp_instrd: got %h want %h", bus.InstrD, NOP); end
        idle_inputs();
        bus.JumpPre = 1; bus.JumpPrePC = 32'h300; bus.InstrF = 32'h1234_5678;
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b1) begin n_fail++; $display("FAIL mp_flushde_c2: got %b want 1", bus.FlushDE); end
        step();
        n_cmp++; if (bus.PCF !== 32'h18) begin n_fail++; $display("FAIL mp_recover_ignores_pre: got %h want %h", bus.PCF, 32'h18); end
        n_cmp++; if (bus.InstrD !== 32'h1234_5678) begin n_fail++; $display("FAIL mp_recover_instrd: got %h want %h", bus.InstrD, 32'h1234_5678); end
        n_cmp++; if (bus.PredTakenD !== 1'b0) begin n_fail++; $display("FAIL mp_recover_pred: got %b want 0", bus.PredTakenD); end
        bus.JumpPre = 0;
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL mp_flushde_c3: got %b want 0", bus.FlushDE); end
    endtask

    task automatic test_mis_jump();
        bus.BranchMEM = 1; bus.PredTakenMEM = 0; bus.PCSrcMEM = 1;
        bus.PCBranchMEM = 32'h80; bus.PCPlus4MEM = 32'h1C;
        bus.JumpD = 1; bus.JumpTargetD = 32'h200;
        step();
        n_cmp++; if (bus.PCF !== 32'h80) begin n_fail++; $display("FAIL mj_pcf: got %h want %h", bus.PCF, 32'h80); end
        n_cmp++; if (bus.MispredCnt !== 16'd2) begin n_fail++; $display("FAIL mj_cnt: got %0d want 2", bus.MispredCnt); end
        idle_inputs();
        step();
        n_cmp++; if (bus.PCF !== 32'h84) begin n_fail++; $display("FAIL mj_recover_pcf: got %h want %h", bus.PCF, 32'h84); end
        bus.JumpD = 1; bus.JumpTargetD = 32'h200;
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL jd_flushde: got %b want 0", bus.FlushDE); end
        step();
        n_cmp++; if (bus.PCF !== 32'h200) begin n_fail++; $display("FAIL jd_pcf: got %h want %h", bus.PCF, 32'h200); end
        n_cmp++; if (bus.InstrD !== NOP) begin n_fail++; $display("FAIL jd_instrd: got %h want %h", bus.InstrD, NOP); end
        idle_inputs();
    endtask

    task automatic test_wrap_reset();
        bus.JumpD = 1; bus.JumpTargetD = 32'hFFFF_FFFC;
        step();
        n_cmp++; if (bus.PCF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_top_pcf: got %h want %h", bus.PCF, 32'hFFFF_FFFC); end
        idle_inputs();
        bus.InstrF = 32'h0BAD_0001;
        step();
        n_cmp++; if (bus.PCF !== 32'h0) begin n_fail++; $display("FAIL wr_pcf: got %h want %h", bus.PCF, 32'h0); end
        n_cmp++; if (bus.PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL wr_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h0); end
        bus.BranchMEM = 1; bus.PredTakenMEM = 0; bus.PCSrcMEM = 1; bus.PCBranchMEM = 32'h500;
        step();
        n_cmp++; if (bus.PCF !== 32'h500) begin n_fail++; $display("FAIL wr_mp_pcf: got %h want %h", bus.PCF, 32'h500); end
        n_cmp++; if (bus.MispredCnt !== 16'd3) begin n_fail++; $display("FAIL wr_mp_cnt: got %0d want 3", bus.MispredCnt); end
        idle_inputs();
        #1;
        n_cmp++; if (bus.FlushDE !== 1'b1) begin n_fail++; $display("FAIL wr_recover_flushde: got %b want 1", bus.FlushDE); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.PCF !== 32'h0) begin n_fail++; $display("FAIL wr_rst_pcf: got %h want %h", bus.PCF, 32'h0); end
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL wr_rst_flushde: got %b want 0", bus.FlushDE); end
        n_cmp++; if (bus.MispredCnt !== 16'd0) begin n_fail++; $display("FAIL wr_rst_cnt: got %0d want 0", bus.MispredCnt); end
        n_cmp++; if (bus.PCPlus4D !== 32'h4) begin n_fail++; $display("FAIL wr_rst_pcplus4d: got %h want %h", bus.PCPlus4D, 32'h4); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.PCF !== 32'h4) begin n_fail++; $display("FAIL wr_first_fetch: got %h want %h", bus.PCF, 32'h4); end
        n_cmp++; if (bus.FlushDE !== 1'b0) begin n_fail++; $display("FAIL wr_post_rst_flushde: got %b want 0", bus.FlushDE); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        sbus.BranchMEM = 1; sbus.PredTakenMEM = 1; sbus.PCSrcMEM = 0; sbus.PCPlus4MEM = 32'h20;
        exp_cnt = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'd1;
            n_cmp++; if (sbus.MispredCnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, sbus.MispredCnt, exp_cnt); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_pre();
        test_stall();
        test_mispredict();
        test_mis_jump();
        test_wrap_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
